// File: rtl/iir_dac_tx.sv
// iir_dac_tx: rounds/saturates signed 16-bit IIR samples to 8-bit offset binary, queues them, and sends 16-bit SPI mode-0 DAC frames
// Ports:
//   clk          in   system clock, posedge
//   rst_n        in   asynchronous active-low reset; aborts any frame in flight
//   i_s_data     in   signed 16-bit sample
//   i_s_valid    in   sample valid
//   o_s_ready    out  FIFO not full; transfer on i_s_valid && o_s_ready
//   o_dac_sclk   out  SPI clock, idle low
//   o_dac_cs_n   out  SPI chip select, active low
//   o_dac_sdo    out  SPI data, MSB first
//   o_busy       out  frame in progress or samples queued
//   o_sat_flag   out  one-cycle pulse after a saturated sample was accepted
module iir_dac_tx #(
    parameter int         CLK_DIV    = 4,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] DAC_CMD    = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_s_data,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    output logic        o_dac_sclk,
    output logic        o_dac_cs_n,
    output logic        o_dac_sdo,
    output logic        o_busy,
    output logic        o_sat_flag
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0]    r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic [15:0]   r_shift;
    logic [DW-1:0] r_div;
    logic [4:0]    r_half;
    logic          r_sclk;
    logic          r_cs_n;
    logic          r_sat;

    logic [8:0] w_hi;
    logic [7:0] w_unused_lo;
    logic [7:0] w_byte;
    logic       w_ovf;
    logic       w_push;
    logic       w_pop;
    logic       w_tick;

    // Rounding adds half an LSB of the 8-bit result; only the positive side can overflow.
    assign {w_hi, w_unused_lo} = {i_s_data[15], i_s_data} + 17'h00080;
    assign w_ovf  = ~w_hi[8] & w_hi[7];
    assign w_byte = w_ovf ? 8'h7F : w_hi[7:0];
    assign o_s_ready = r_cnt != (AW+1)'(FIFO_DEPTH);
    assign w_push = i_s_valid & o_s_ready;
    assign w_pop  = r_state == LOAD;
    assign w_tick = r_div == DW'(CLK_DIV - 1);

    assign o_dac_sclk = r_sclk;
    assign o_dac_cs_n = r_cs_n;
    assign o_dac_sdo  = r_shift[15];
    assign o_busy     = (r_state != IDLE) | (r_cnt != '0);
    assign o_sat_flag = r_sat;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {~w_byte[7], w_byte[6:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_div   <= '0;
            r_half  <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sat   <= 1'b0;
        end else begin
            r_sat <= w_push & w_ovf;
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            case (r_state)
                IDLE: if (r_cnt != '0) begin
                    r_state <= LOAD;
                    r_cs_n  <= 1'b0;
                    r_shift <= {DAC_CMD, r_mem[r_rd], 4'b0000};
                end
                LOAD: begin
                    r_state <= SHIFT;
                    r_div   <= '0;
                    r_half  <= '0;
                end
                SHIFT: if (w_tick) begin
                    r_div  <= '0;
                    r_sclk <= ~r_sclk;
                    r_half <= r_half + 5'd1;
                    // Data moves on falling edges; the final falling edge closes the frame instead.
                    if (r_sclk) begin
                        if (r_half == 5'd31) begin
                            r_state <= GAP;
                            r_cs_n  <= 1'b1;
                            r_shift <= '0;
                        end else begin
                            r_shift <= {r_shift[14:0], 1'b0};
                        end
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
                GAP: if (r_div == DW'(2 * CLK_DIV - 1)) r_state <= IDLE;
                     else r_div <= r_div + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_dac_tx.sv
// tb_iir_dac_tx: self-checking bench for iir_dac_tx with CLK_DIV=4 and CLK_DIV=1 instances
module tb_iir_dac_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data [2];
    logic        s_valid [2];
    logic        s_ready [2];
    logic        sclk [2];
    logic        cs_n [2];
    logic        sdo [2];
    logic        busy [2];
    logic        sat [2];

    always #5 clk = ~clk;

    iir_dac_tx #(.CLK_DIV(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_s_data(s_data[0]), .i_s_valid(s_valid[0]), .o_s_ready(s_ready[0]),
        .o_dac_sclk(sclk[0]), .o_dac_cs_n(cs_n[0]), .o_dac_sdo(sdo[0]), .o_busy(busy[0]), .o_sat_flag(sat[0])
    );
    iir_dac_tx #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_s_data(s_data[1]), .i_s_valid(s_valid[1]), .o_s_ready(s_ready[1]),
        .o_dac_sclk(sclk[1]), .o_dac_cs_n(cs_n[1]), .o_dac_sdo(sdo[1]), .o_busy(busy[1]), .o_sat_flag(sat[1])
    );

    typedef struct { logic [15:0] data; logic [7:0] code; logic sat; } vec_t;
    vec_t tbl [10];

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    logic        exp_sat [2];
    int          acc_cnt [2];
    int          seen [2];

    // Frames observed on the SPI pins
    logic [15:0] f_word [2][128];
    int          f_low [2][128];
    int          f_bits [2][128];
    int          f_hi [2][128];
    int          f_gap [2][128];
    int          nf [2];
    int          m_rises [2];
    logic [15:0] m_sh [2];
    int          m_bits [2];
    int          m_low [2];
    int          m_hi [2];
    int          m_idle [2];
    int          m_gap [2];
    logic        m_psclk [2];
    logic        m_pcs [2];

    function automatic logic [7:0] model_code(input logic [15:0] d);
        int r;
        int b;
        r = int'($signed(d)) + 128;
        b = (r > 32767) ? 127 : (r >>> 8);
        return 8'(b + 128);
    endfunction

    function automatic logic model_sat(input logic [15:0] d);
        return int'($signed(d)) + 128 > 32767;
    endfunction

    function automatic logic [15:0] model_word(input logic [15:0] d);
        return 16'h3000 + 16'(int'(model_code(d)) * 16);
    endfunction

    function automatic logic [15:0] rnd_sample();
        case ($urandom_range(0, 9))
            0: return 16'h7FFF;
            1: return 16'h7F80;
            2: return 16'h7F7F;
            3: return 16'h8000;
            4: return 16'hFF80;
            5: return 16'hFF7F;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        logic acc;
        for (int m = 0; m < 2; m++) begin
            acc = s_valid[m] && s_ready[m] && rst_n;
            if (acc) begin
                acc_cnt[m]++;
                if (m == 0) exp_q0.push_back(model_word(s_data[m]));
                else exp_q1.push_back(model_word(s_data[m]));
            end
            exp_sat[m] = acc && model_sat(s_data[m]);
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++)
            if (exp_sat[m] || sat[m]) chk($sformatf("sat_flag dut%0d", m), int'(sat[m]), int'(exp_sat[m]));
    endtask

    task automatic wait_idle(output int t);
        t = 0;
        while ((busy[0] || busy[1]) && t < 3000) begin
            tick();
            t++;
        end
        chk("drain before timeout", int'(busy[0] || busy[1]), 0);
        tick();
        tick();
    endtask

    task automatic check_frames(input int m);
        int n;
        int dv;
        dv = (m == 0) ? 4 : 1;
        n = (m == 0) ? exp_q0.size() : exp_q1.size();
        chk($sformatf("dut%0d frame count", m), nf[m] - seen[m], n);
        for (int i = 0; i < n && seen[m] + i < nf[m]; i++) begin
            chk($sformatf("dut%0d frame %0d word", m, i), int'(f_word[m][seen[m]+i]), int'((m == 0) ? exp_q0[i] : exp_q1[i]));
            chk($sformatf("dut%0d frame %0d cs_n low clks", m, i), f_low[m][seen[m]+i], 1 + 32 * dv);
            chk($sformatf("dut%0d frame %0d sclk rises", m, i), f_bits[m][seen[m]+i], 16);
            chk($sformatf("dut%0d frame %0d sclk high clks", m, i), f_hi[m][seen[m]+i], 16 * dv);
        end
        seen[m] = nf[m];
        if (m == 0) exp_q0.delete();
        else exp_q1.delete();
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            nf[m] = 0; m_rises[m] = 0; m_sh[m] = '0; m_bits[m] = 0; m_low[m] = 0;
            m_hi[m] = 0; m_idle[m] = 0; m_gap[m] = 0; m_psclk[m] = 1'b0; m_pcs[m] = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!rst_n) begin
                    nf[m] = 0; m_rises[m] = 0; m_idle[m] = 0; m_psclk[m] = 1'b0; m_pcs[m] = 1'b1;
                end else begin
                    if (sclk[m] && !m_psclk[m]) m_rises[m]++;
                    if (!cs_n[m]) begin
                        if (m_pcs[m]) begin
                            m_gap[m] = m_idle[m]; m_sh[m] = '0; m_bits[m] = 0; m_low[m] = 0; m_hi[m] = 0;
                        end
                        m_low[m]++;
                        if (sclk[m]) m_hi[m]++;
                        if (sclk[m] && !m_psclk[m]) begin
                            m_sh[m] = {m_sh[m][14:0], sdo[m]};
                            m_bits[m]++;
                        end
                    end else begin
                        if (!m_pcs[m]) begin
                            if (nf[m] < 128) begin
                                f_word[m][nf[m]] = m_sh[m]; f_low[m][nf[m]] = m_low[m]; f_bits[m][nf[m]] = m_bits[m];
                                f_hi[m][nf[m]] = m_hi[m]; f_gap[m][nf[m]] = m_gap[m];
                                nf[m]++;
                            end
                            m_idle[m] = 0;
                        end
                        m_idle[m]++;
                    end
                    m_psclk[m] = sclk[m];
                    m_pcs[m] = cs_n[m];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        int base;
        int first_low;
        logic [15:0] burst [10];
        tbl[0] = '{16'h0000, 8'h80, 1'b0};
        tbl[1] = '{16'h1280, 8'h93, 1'b0};
        tbl[2] = '{16'h127F, 8'h92, 1'b0};
        tbl[3] = '{16'h8000, 8'h00, 1'b0};
        tbl[4] = '{16'h7FFF, 8'hFF, 1'b1};
        tbl[5] = '{16'h7F80, 8'hFF, 1'b1};
        tbl[6] = '{16'h7F7F, 8'hFF, 1'b0};
        tbl[7] = '{16'hFF80, 8'h80, 1'b0};
        tbl[8] = '{16'hFF7F, 8'h7F, 1'b0};
        tbl[9] = '{16'h0100, 8'h81, 1'b0};
        for (int m = 0; m < 2; m++) begin
            s_data[m] = '0; s_valid[m] = 1'b0; exp_sat[m] = 1'b0; acc_cnt[m] = 0; seen[m] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset s_ready", int'(s_ready[0]), 1);
        chk("reset sclk", int'(sclk[0]), 0);
        chk("reset cs_n", int'(cs_n[0]), 1);
        chk("reset sdo", int'(sdo[0]), 0);
        chk("reset busy", int'(busy[0]), 0);
        chk("reset sat_flag", int'(sat[0]), 0);
        rst_n = 1'b1;
        tick();

        s_data[0] = 16'h0000;
        s_valid[0] = 1'b1;
        tick();
        s_valid[0] = 1'b0;
        chk("busy after accept", int'(busy[0]), 1);
        wait_idle(t);
        chk("busy duration single frame", t, 2 + 34 * 4);
        chk("frame for 0x0000", nf[0] > seen[0] ? int'(f_word[0][nf[0]-1]) : -1, 16'h3800);
        check_frames(0);

        foreach (tbl[i]) begin
            s_data[0] = tbl[i].data;
            s_valid[0] = 1'b1;
            tick();
            s_valid[0] = 1'b0;
            chk($sformatf("table %0d sat_flag", i), int'(sat[0]), int'(tbl[i].sat));
            wait_idle(t);
            chk($sformatf("table %0d word", i), nf[0] > seen[0] ? int'(f_word[0][nf[0]-1]) : -1, int'({4'h3, tbl[i].code, 4'h0}));
            check_frames(0);
        end

        foreach (burst[i]) burst[i] = rnd_sample();
        base = acc_cnt[0];
        first_low = -1;
        k = 0;
        t = 0;
        s_valid[0] = 1'b1;
        while (k < 10 && t < 5000) begin
            s_data[0] = burst[k];
            if (!s_ready[0] && first_low < 0) begin
                first_low = acc_cnt[0] - base;
                chk("frame active when FIFO full", int'(cs_n[0]), 0);
            end
            if (s_ready[0]) k++;
            tick();
            t++;
        end
        s_valid[0] = 1'b0;
        chk("burst samples accepted", k, 10);
        chk("accepted before s_ready drop", first_low, 4 + 1);
        wait_idle(t);
        check_frames(0);

        s_data[0] = 16'h5A5A;
        s_valid[0] = 1'b1;
        tick();
        s_valid[0] = 1'b0;
        t = 0;
        while (!(m_bits[0] == 9 && sclk[0]) && t < 500) begin
            tick();
            t++;
        end
        chk("reached bit 7 before reset", int'(m_bits[0] == 9 && sclk[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset cs_n", int'(cs_n[0]), 1);
        chk("async reset sclk", int'(sclk[0]), 0);
        exp_q0.delete();
        exp_q1.delete();
        exp_sat[0] = 1'b0;
        exp_sat[1] = 1'b0;
        tick();
        tick();
        seen[0] = 0;
        seen[1] = 0;
        rst_n = 1'b1;
        tick();
        chk("after reset s_ready", int'(s_ready[0]), 1);
        chk("after reset busy", int'(busy[0]), 0);
        repeat (100) tick();
        chk("sclk rises after reset", m_rises[0], 0);
        chk("frames after reset", nf[0], 0);
        chk("cs_n idle after reset", int'(cs_n[0]), 1);

        base = nf[1];
        for (int i = 0; i < 3; i++) begin
            s_data[1] = rnd_sample();
            s_valid[1] = 1'b1;
            tick();
        end
        s_valid[1] = 1'b0;
        wait_idle(t);
        chk("div1 frames emitted", nf[1] - base, 3);
        if (nf[1] - base >= 3) begin
            chk("div1 cs_n high between frames 1-2", f_gap[1][base+1], 2 * 1 + 1);
            chk("div1 cs_n high between frames 2-3", f_gap[1][base+2], 2 * 1 + 1);
        end
        check_frames(1);

        s_data[0] = 16'h2345;
        s_valid[0] = 1'b1;
        tick();
        s_valid[0] = 1'b0;
        chk("one queued, still idle", int'(cs_n[0]), 1);
        tick();
        chk("LOAD cycle cs_n", int'(cs_n[0]), 0);
        chk("LOAD cycle s_ready", int'(s_ready[0]), 1);
        s_data[0] = 16'hC3A0;
        s_valid[0] = 1'b1;
        tick();
        s_valid[0] = 1'b0;
        chk("queued after push+pop", int'(busy[0]), 1);
        wait_idle(t);
        check_frames(0);

        for (int c = 0; c < 800; c++) begin
            for (int m = 0; m < 2; m++) begin
                s_data[m] = rnd_sample();
                s_valid[m] = $urandom_range(0, (m == 0) ? 9 : 2) == 0;
            end
            tick();
        end
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        wait_idle(t);
        check_frames(0);
        check_frames(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
